conv3x3_window_ctrl: RTL and testbench
======================================

Name: conv3x3_window_ctrl

Overview:
Sequencer that feeds a single-channel 3x3 convolution datapath from a raster-order pixel stream.
- Buffers two image rows and builds the 3x3 window for every valid output position (no padding).
- Pulses the window-valid strobe to the conv unit and counts the conv unit's output strobes.
- Signals frame completion.
- Sits between the input-feature-map source and the conv3x3 datapath; one instance per channel.

Parameters:
DATA_W, 8, pixel/window element width (signed)
IMG_W, 28, image width in pixels, legal range 3..1024
IMG_H, 28, image height in pixels, legal range 3..1024

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle pulse; begins a frame when idle
pix_in  input  DATA_W  signed input pixel, raster order
pix_in_valid  input  1  pixel present
pix_in_ready  output  1  controller accepts pixel this cycle
win_valid  output  1  window outputs valid; drives conv in_valid
p00..p22  output  DATA_W each  window: pRC = pixel(row r-2+R, col c-2+C)
conv_out_valid  input  1  output strobe from conv datapath
busy  output  1  frame in progress (not IDLE)
done  output  1  one-cycle pulse when frame completes

Behaviour:
- Reset values: pix_in_ready=0, win_valid=0, p00..p22=0, busy=0, done=0. Row/col/output counters=0, state=IDLE. Line-buffer contents are not cleared.
- Pixel accept: pix_in_valid & pix_in_ready.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: pix_in_ready=1. Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: pix_in_ready=0. When output count reaches OUT_N=(IMG_W-2)*(IMG_H-2) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Counters:
  - col increments on accept and wraps IMG_W-1 -> 0.
  - row increments on col wrap.
  - Both clear on start.
- Line buffers: two IMG_W-deep rows, delayed by one and two rows. Read and written at the col address on each accept.
- Window: 3 columns of 3 regs shift left on every accept, with the new column {row-2, row-1, current} entering at p02/p12/p22.
- win_valid: registered. High the cycle after accepting pixel (r,c) with r>=2 and c>=2; low otherwise, including at row starts where c<2. Exactly OUT_N pulses per frame.
- Latency: pixel accept -> window on outputs = 1 cycle.
- Output counting: conv_out_valid increments the output counter in RUN and DRAIN; ignored in IDLE/DONE. Counter saturates at OUT_N.
- Gaps in pix_in_valid: state, counters and window hold; win_valid=0.
- start while busy: ignored.
- Simultaneous last-pixel accept and conv_out_valid: both take effect in that cycle.
- rst mid-frame: immediate return to IDLE with all reset values; a partial frame is discarded.
- Widths:
  - row/col counters clog2(IMG_H) and clog2(IMG_W).
  - Output counter clog2(OUT_N+1).
  - Window data passes through unmodified (no arithmetic).

Optional Feature:
Macro CONV3X3_WIN_BP_EN.
- Defined: adds input win_ready (1 bit).
  - pix_in_ready = RUN & (win_ready | ~win_valid).
  - win_valid and p00..p22 hold while win_valid & ~win_ready; the window is consumed on win_valid & win_ready.
  - Everything else unchanged.
- Undefined: no win_ready port; the conv unit always accepts, and behaviour is exactly as above.

Test Plan:
- IMG_W=4, IMG_H=4, pixel value = raster index 0..15, pix_in_valid continuous after start -> exactly 4 win_valid pulses. First window p00..p22 = 0,1,2,4,5,6,8,9,10. Last window = 5,6,7,9,10,11,13,14,15. First pulse the cycle after accepting index 10.
- Same frame with pix_in_valid toggling every other cycle -> identical 4 windows in order. win_valid never high in a cycle following a non-accept.
- Conv model returns conv_out_valid 1 cycle after each win_valid -> done pulses exactly once, 2 cycles after the 4th conv_out_valid. busy falls with IDLE.
- start asserted during RUN at pixel 7 -> ignored. Counters are not cleared and 4 windows are still produced.
- rst asserted after pixel 9 accepted, then new start and full frame -> all outputs 0 the cycle after rst. The next frame yields the correct 4 windows with no stale-window pulse.
- With CONV3X3_WIN_BP_EN, win_ready held low 3 cycles on the 2nd window -> p-values and win_valid held stable and pix_in_ready=0 for those cycles. Still 4 windows total, none duplicated.

Source files
------------

// File: rtl/conv3x3_window_ctrl.sv
// conv3x3_window_ctrl: builds 3x3 windows from a raster pixel stream for one conv channel.
// Optional macro CONV3X3_WIN_BP_EN adds a win_ready backpressure input from the conv unit.
module conv3x3_window_ctrl #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] pix_in,
   input  logic                     pix_in_valid,
   output logic                     pix_in_ready,
`ifdef CONV3X3_WIN_BP_EN
   input  logic                     win_ready,
`endif
   output logic                     win_valid,
   output logic signed [DATA_W-1:0] p00,
   output logic signed [DATA_W-1:0] p01,
   output logic signed [DATA_W-1:0] p02,
   output logic signed [DATA_W-1:0] p10,
   output logic signed [DATA_W-1:0] p11,
   output logic signed [DATA_W-1:0] p12,
   output logic signed [DATA_W-1:0] p20,
   output logic signed [DATA_W-1:0] p21,
   output logic signed [DATA_W-1:0] p22,
   input  logic                     conv_out_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int OUT_N = (IMG_W - 2) * (IMG_H - 2);
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int OW    = $clog2(OUT_N + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [OW-1:0] OUT_LAST = OW'(OUT_N);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [OW-1:0] r_out_cnt;
   logic          r_win_valid;

   logic signed [DATA_W-1:0] r_lb1 [IMG_W];
   logic signed [DATA_W-1:0] r_lb2 [IMG_W];

   logic signed [DATA_W-1:0] r_p00, r_p01, r_p02;
   logic signed [DATA_W-1:0] r_p10, r_p11, r_p12;
   logic signed [DATA_W-1:0] r_p20, r_p21, r_p22;

   logic w_hold;
   logic w_accept;
   logic w_col_wrap;
   logic w_last_pix;
   logic w_win_hit;
   logic w_cnt_en;
   logic w_idle_start;

   // A window still waiting on the conv unit blocks new pixels.
`ifdef CONV3X3_WIN_BP_EN
   assign w_hold = r_win_valid & ~win_ready;
`else
   assign w_hold = 1'b0;
`endif

   assign pix_in_ready = (r_state == S_RUN) & ~w_hold;
   assign w_accept     = pix_in_valid & pix_in_ready;
   assign w_col_wrap   = (r_col == COL_LAST);
   assign w_last_pix   = w_col_wrap & (r_row == ROW_LAST);
   assign w_win_hit    = (r_row >= ROW_TWO) & (r_col >= COL_TWO);
   assign w_idle_start = (r_state == S_IDLE) & start;

   assign w_cnt_en = conv_out_valid
                   & ((r_state == S_RUN) | (r_state == S_DRAIN))
                   & (r_out_cnt != OUT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_accept && w_last_pix) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_out_cnt == OUT_LAST) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_idle_start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= w_last_pix ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_cnt <= '0;
      end else if (w_idle_start) begin
         r_out_cnt <= '0;
      end else if (w_cnt_en) begin
         r_out_cnt <= r_out_cnt + 1'b1;
      end
   end

   // Row memories are never cleared; the window is only valid once both are refilled.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb1[r_col] <= pix_in;
         r_lb2[r_col] <= r_lb1[r_col];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p00 <= '0;
         r_p01 <= '0;
         r_p02 <= '0;
         r_p10 <= '0;
         r_p11 <= '0;
         r_p12 <= '0;
         r_p20 <= '0;
         r_p21 <= '0;
         r_p22 <= '0;
      end else if (w_accept) begin
         r_p00 <= r_p01;
         r_p01 <= r_p02;
         r_p02 <= r_lb2[r_col];
         r_p10 <= r_p11;
         r_p11 <= r_p12;
         r_p12 <= r_lb1[r_col];
         r_p20 <= r_p21;
         r_p21 <= r_p22;
         r_p22 <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_win_valid <= 1'b0;
      end else if (w_accept) begin
         r_win_valid <= w_win_hit;
      end else if (!w_hold) begin
         r_win_valid <= 1'b0;
      end
   end

   assign win_valid = r_win_valid;
   assign p00       = r_p00;
   assign p01       = r_p01;
   assign p02       = r_p02;
   assign p10       = r_p10;
   assign p11       = r_p11;
   assign p12       = r_p12;
   assign p20       = r_p20;
   assign p21       = r_p21;
   assign p22       = r_p22;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Directed bench for conv3x3_window_ctrl on a 4x4 frame of raster-index pixels.
// Backpressure steps are built only when CONV3X3_WIN_BP_EN is defined.
`timescale 1ns/1ps
module tb_conv3x3_window_ctrl;

   localparam int DW   = 8;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;
   localparam int NOUT = (W - 2) * (H - 2);

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic signed [DW-1:0] pix_in;
   logic pix_in_valid;
   logic pix_in_ready;
   logic win_ready;
   logic win_valid;
   logic signed [DW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
   logic conv_out_valid;
   logic busy;
   logic done;

   always #5 clk = ~clk;

   conv3x3_window_ctrl #(
      .DATA_W(DW),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .pix_in        (pix_in),
      .pix_in_valid  (pix_in_valid),
      .pix_in_ready  (pix_in_ready),
`ifdef CONV3X3_WIN_BP_EN
      .win_ready     (win_ready),
`endif
      .win_valid     (win_valid),
      .p00           (p00),
      .p01           (p01),
      .p02           (p02),
      .p10           (p10),
      .p11           (p11),
      .p12           (p12),
      .p20           (p20),
      .p21           (p21),
      .p22           (p22),
      .conv_out_valid(conv_out_valid),
      .busy          (busy),
      .done          (done)
   );

   int checks   = 0;
   int failures = 0;

   int ncyc          = 0;
   int pix_idx       = 0;
   int nwin          = 0;
   int ndone         = 0;
   int done_cyc      = -1;
   int last_cov      = -1;
   int stale         = 0;
   int acc10_cyc     = -1;
   int first_win_cyc = -1;
   int hold          = 0;
   bit bp_mode       = 1'b0;
   logic [71:0] wins [16];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] win_now();
      return {p00, p01, p02, p10, p11, p12, p20, p21, p22};
   endfunction

   // Window k covers output (r,c) in raster order; element pRC = index of pixel (r-2+R, c-2+C).
   function automatic logic [71:0] exp_win(input int k);
      logic [71:0] v;
      int r;
      int c;
      v = '0;
      r = 2 + k / (W - 2);
      c = 2 + k % (W - 2);
      for (int R = 0; R < 3; R++)
         for (int C = 0; C < 3; C++)
            v = {v[63:0], 8'((r - 2 + R) * W + (c - 2 + C))};
      return v;
   endfunction

   task automatic cyc();
      bit acc;
      bit cons;
      bit held;
      acc  = pix_in_valid && pix_in_ready;
      cons = win_valid && win_ready;
      held = win_valid && !win_ready;
      @(posedge clk);
      #1;
      ncyc++;
      if (acc) begin
         if (pix_idx == 10) acc10_cyc = ncyc;
         pix_idx++;
      end
      if (win_valid && !acc && !held) stale++;
      conv_out_valid = cons;
      if (cons) last_cov = ncyc;
      if (done) begin
         ndone++;
         done_cyc = ncyc;
      end
      if (bp_mode && win_valid && nwin == 1 && hold < 3) begin
         win_ready = 1'b0;
         hold++;
         #1;
         chk("bp_ready_low", int'(pix_in_ready), 0);
         chkw("bp_win_held", win_now(), exp_win(1));
      end else begin
         win_ready = 1'b1;
      end
      if (win_valid && win_ready && nwin < 16) begin
         if (nwin == 0) first_win_cyc = ncyc;
         wins[nwin] = win_now();
         nwin++;
      end
      #1;
   endtask

   task automatic run_frame(input bit tog, input int start_at, input int abort_at);
      bit mid_started;
      mid_started   = 1'b0;
      nwin          = 0;
      ndone         = 0;
      pix_idx       = 0;
      stale         = 0;
      acc10_cyc     = -1;
      first_win_cyc = -1;
      last_cov      = -1;
      done_cyc      = -1;
      hold          = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (ndone > 0) break;
         if (abort_at >= 0 && pix_idx > abort_at) break;
         pix_in_valid = (pix_idx < NPIX) && (!tog || (i % 2 == 0));
         pix_in       = DW'(pix_idx);
         start        = 1'b0;
         if (start_at >= 0 && pix_idx == start_at && !mid_started) begin
            start       = 1'b1;
            mid_started = 1'b1;
         end
         cyc();
      end
      start        = 1'b0;
      pix_in_valid = 1'b0;
   endtask

   task automatic chk_windows(input string tag);
      chk({tag, "_nwin"}, nwin, NOUT);
      for (int k = 0; k < NOUT; k++)
         chkw($sformatf("%s_win%0d", tag, k), wins[k], exp_win(k));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, int'(pix_in_ready), 0);
      chk({tag, "_win_valid"}, int'(win_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chkw({tag, "_window"}, win_now(), 72'h0);
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      pix_in_valid   = 1'b0;
      pix_in         = '0;
      conv_out_valid = 1'b0;
      win_ready      = 1'b1;
      cyc();
      cyc();
      chk_zero("reset");
      rst = 1'b0;
      cyc();

      run_frame(1'b0, -1, -1);
      chk_windows("cont");
      chkw("cont_first_hand", wins[0], 72'h00_01_02_04_05_06_08_09_0a);
      chkw("cont_last_hand", wins[3], 72'h05_06_07_09_0a_0b_0d_0e_0f);
      chk("cont_first_latency", first_win_cyc, acc10_cyc);
      chk("cont_done_lat", done_cyc - last_cov, 2);
      chk("cont_busy_in_done", int'(busy), 1);
      cyc();
      chk("cont_busy_fall", int'(busy), 0);
      chk("cont_done_fall", int'(done), 0);
      cyc();
      cyc();
      chk("cont_done_once", ndone, 1);
      chk("cont_stale", stale, 0);

      run_frame(1'b1, -1, -1);
      chk_windows("gap");
      chk("gap_stale", stale, 0);
      chk("gap_done", ndone, 1);
      cyc();
      chk("gap_busy_fall", int'(busy), 0);

      run_frame(1'b0, 7, -1);
      chk_windows("midstart");
      chk("midstart_done", ndone, 1);
      cyc();

      run_frame(1'b0, -1, 9);
      chk("abort_pix", pix_idx, 10);
      rst = 1'b1;
      cyc();
      chk_zero("midrst");
      rst = 1'b0;
      cyc();
      run_frame(1'b0, -1, -1);
      chk_windows("after_rst");
      chkw("after_rst_first", wins[0], 72'h00_01_02_04_05_06_08_09_0a);
      chk("after_rst_stale", stale, 0);
      chk("after_rst_done", ndone, 1);
      cyc();

`ifdef CONV3X3_WIN_BP_EN
      bp_mode = 1'b1;
      run_frame(1'b0, -1, -1);
      bp_mode = 1'b0;
      chk_windows("bp");
      chk("bp_hold_cycles", hold, 3);
      chk("bp_done", ndone, 1);
      cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
